// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port synchronous RAM: requester 0 has priority,
// requester 1 is guaranteed a grant after MAX_BURST contested requester-0 grants.
module ram_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     write0,
    input  logic                     write1,
    input  logic [ADDRESS_WIDTH-1:0] address0,
    input  logic [ADDRESS_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0]    data0,
    input  logic [DATA_WIDTH-1:0]    data1,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     valid0,
    output logic                     valid1,
    output logic [DATA_WIDTH-1:0]    read_data0,
    output logic [DATA_WIDTH-1:0]    read_data1,
    output logic                     ram_read_enable,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    input  logic [DATA_WIDTH-1:0]    ram_read_data
);

    localparam int COUNT_W = $clog2(MAX_BURST + 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_BURST);

    logic [COUNT_W-1:0] starve_count;
    logic [COUNT_W-1:0] starve_next;
    logic               grant0;
    logic               grant1;
    logic               grant;
    logic               win_write;
    logic               issue_read;
    logic               read_pending_p1;
    logic               read_tag_p1;

    // Saturating increment keeps the counter from ever passing MAX_BURST.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        logic [COUNT_W-1:0] result;
        result = value;
        if (value != COUNT_MAX) begin
            result = value + 1'b1;
        end
        return result;
    endfunction

    // Stage p0: combinational grant and RAM command mux.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0 && req1) begin
            if (starve_count == COUNT_MAX) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else if (req0) begin
            grant0 = 1'b1;
        end else if (req1) begin
            grant1 = 1'b1;
        end
    end

    assign grant            = grant0 | grant1;
    assign win_write        = grant1 ? write1 : write0;
    assign issue_read       = grant && !win_write;
    assign ack0             = grant0;
    assign ack1             = grant1;
    assign ram_address      = grant1 ? address1 : address0;
    assign ram_write_data   = grant1 ? data1 : data0;
    assign ram_write_enable = grant && win_write;
    assign ram_read_enable  = issue_read;

    always_comb begin
        starve_next = starve_count;
        if (grant1 || !req1) begin
            starve_next = '0;
        end else if (grant0) begin
            starve_next = sat_inc(starve_count);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_count <= '0;
        end else begin
            starve_count <= starve_next;
        end
    end

    // Stage p1: read response returns one cycle after issue, tagged with its requester.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_pending_p1 <= 1'b0;
            read_tag_p1     <= 1'b0;
        end else begin
            read_pending_p1 <= issue_read;
            if (issue_read) begin
                read_tag_p1 <= grant1;
            end
        end
    end

    assign valid0     = read_pending_p1 && !read_tag_p1;
    assign valid1     = read_pending_p1 && read_tag_p1;
    assign read_data0 = ram_read_data;
    assign read_data1 = ram_read_data;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (registered read data, one-cycle read latency, read and write enables) between a high-priority requester 0 and a low-priority requester 1. It issues at most one RAM command per cycle and routes each read response back to the requester that issued it. A bounded-starvation counter guarantees that requester 1 is served under sustained contention. It sits directly in front of the RAM, and both requesters use a simple req/ack handshake.

## Interface
- ADDRESS_WIDTH, 16, RAM address width
- DATA_WIDTH, 8, data word width
- MAX_BURST, 4, max consecutive contested grants to requester 0 before requester 1 wins; legal range ≥1
- Clock  input  1  single clock, all state on rising edge
- Reset  input  1  one clock; reset is asynchronous and active-high
- Req0_i / Req1_i  input  1  command request from requester 0 / 1
- Write0_i / Write1_i  input  1  1 = write, 0 = read
- Address0_i / Address1_i  input  ADDRESS_WIDTH  command address
- Data0_i / Data1_i  input  DATA_WIDTH  write data
- Ack0_o / Ack1_o  output  1  combinational; command accepted at this rising edge
- Valid0_o / Valid1_o  output  1  read data valid for requester 0 / 1
- Data0_o / Data1_o  output  DATA_WIDTH  read data, both driven from RamData_i
- RamReadEnable_o  output  1  RAM read enable
- RamWriteEnable_o  output  1  RAM write enable
- RamAddress_o  output  ADDRESS_WIDTH  RAM address
- RamData_o  output  DATA_WIDTH  RAM write data
- RamData_i  input  DATA_WIDTH  RAM registered read data

## Operation
- **Handshake.** A requester holds Req, Write, Address and Data stable until it sees Ack high. A command transfers on the rising edge where Req && Ack. The requester may drop Req or present a new command in the following cycle.
- **Grant logic (combinational from Req and state).**
  - Only one requester active: grant it.
  - Both active: grant requester 1 if StarveCount == MAX_BURST, else grant requester 0.
  - Neither active: no grant, and all Ram*Enable_o are 0.
- **RAM command.** RamAddress_o and RamData_o are muxed from the winner's inputs.
  - RamWriteEnable_o = grant && Write.
  - RamReadEnable_o = grant && !Write.
  - With no grant, the address and data mux select requester 0 and both enables are 0.
- **StarveCount** (width clog2(MAX_BURST+1)):
  - Increments when requester 0 is granted while Req1_i is high.
  - Clears to 0 when requester 1 is granted, or when Req1_i is low.
  - Never exceeds MAX_BURST.
- **Read tag.** The registered ReadTag records which requester issued a read, and ReadPending records that a read was issued in the previous cycle.
  - Valid0_o = ReadPending && ReadTag == 0.
  - Valid1_o = ReadPending && ReadTag == 1.
  - Data0_o = Data1_o = RamData_i.
- Writes produce no response; Ack is their only completion indication.

## Timing
- **Reset values (while Reset is high):**
  - StarveCount = 0, ReadPending = 0, ReadTag = 0.
  - Valid0_o = Valid1_o = 0.
  - Ack outputs and RAM enables follow Req combinationally and must be ignored by the RAM while in reset.
- **Reset mid-operation.** A read accepted in the cycle of Reset assertion produces no Valid, and the in-flight read response is discarded.
- **Read latency.** Ack at edge N, then Valid and data for the issuing requester are high in cycle N+1, for exactly one cycle.
- **Throughput.** One command per cycle. Back-to-back reads from alternating requesters give alternating Valid0/Valid1 on consecutive cycles.
- **Read after write.** A write at edge N followed by a read of the same address at edge N+1 returns the new data in cycle N+2.
- **Fixed priority.** Requester 0 with Req held continuously and Req1 low gets Ack every cycle; StarveCount stays 0.
- **Contention pattern.** With MAX_BURST = M and both requesters held high, grants follow the repeating pattern M × requester 0, then 1 × requester 1.

## Test plan
- **Reset:** Reset high for 3 cycles with Req0 = 1 read → Valid0/Valid1 = 0 throughout; StarveCount = 0 after release.
- **Write then read, requester 0:** write 0xA5 to 0x0010, then read 0x0010 → Ack0 on both cycles; Valid0 = 1 with Data0_o = 0xA5 one cycle after the read Ack; Valid1 stays 0.
- **Contention:** MAX_BURST = 4, Req0 and Req1 both held as reads for 15 cycles → Ack0 ×4, Ack1 ×1, repeated 3 times; Valid tags match the issuing requester each following cycle.
- **Alternating reads:** requester 0 reads 0x0001 (contains 0x11), then requester 1 reads 0x0002 (contains 0x22), consecutive cycles → Valid0 with 0x11, then Valid1 with 0x22 on the next cycle.
- **Starvation counter clear:** Req1 drops after 2 contested requester-0 grants, then returns → requester 1 waits the full 4 contested grants again.
- **Reset mid-read:** Reset asserted in the cycle after Ack1 for a read → Valid1 never asserts.
